// File: rtl/block_serial_subtractor_pkg.sv
// Shared definitions for the block-serial subtractor.
// Contents:
//   state_t     - control states of the sequencer (IDLE, BUSY, DONE)
//   signed_ovf  - two's-complement overflow of a subtraction, computed from
//                 the minuend, subtrahend and difference sign bits
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A - B overflows only when the operands differ in sign and the result
    // sign differs from the minuend sign.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage

// File: rtl/block_serial_subtractor_subtract_block.sv
// One BLOCK_SIZE-bit slice of a borrow-bypass subtractor.
// Ports:
//   a, b        - minuend / subtrahend bits of the current block
//   borrow_in   - borrow entering the block (from the previous block)
//   diff        - a - b - borrow_in for this block
//   borrow_out  - borrow leaving the block
//   skip        - 1 when every bit pair is equal, so the borrow bypasses
module subtract_block #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  borrow_in,
    output logic [BLOCK_SIZE-1:0] diff,
    output logic                  borrow_out,
    output logic                  skip
);

    // Ripple-borrow through the block, with the bypass mux on the block exit.
    always_comb begin
        logic br_v;
        br_v = borrow_in;
        diff = {BLOCK_SIZE{1'b0}};
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            diff[i] = a[i] ^ b[i] ^ br_v;
            br_v    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br_v);
        end
        skip = &(~(a ^ b));
        // With all pairs equal the ripple result equals borrow_in anyway; the
        // mux just makes the short path explicit.
        if (skip) begin
            borrow_out = borrow_in;
        end else begin
            borrow_out = br_v;
        end
    end

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial subtractor: computes A - B - Bin one BLOCK_SIZE-bit block per
// clock, LSB block first, behind a valid/ready handshake on each side.
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  - operand handshake; A, B, Bin sampled on accept
//   out_valid / out_ready- result handshake; results held until accepted
//   Diff                 - A - B - Bin mod 2^WIDTH
//   Bout                 - final borrow (unsigned A < B + Bin)
//   V                    - signed overflow
//   skip_mask            - bit j set when block j bypassed the borrow
module block_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             V,
    output logic [WIDTH/BLOCK_SIZE-1:0] skip_mask
);

    localparam int NBLK = WIDTH / BLOCK_SIZE;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    if (WIDTH % BLOCK_SIZE != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of BLOCK_SIZE");
    end

    state_t                             state_r;
    state_t                             state_s;
    logic [NBLK-1:0][BLOCK_SIZE-1:0]    a_r;
    logic [NBLK-1:0][BLOCK_SIZE-1:0]    b_r;
    logic [NBLK-1:0][BLOCK_SIZE-1:0]    diff_r;
    logic                               borrow_r;
    logic [CW-1:0]                      count_r;
    logic                               bout_r;
    logic                               v_r;
    logic [NBLK-1:0]                    skip_r;

    logic [BLOCK_SIZE-1:0]              blk_diff_s;
    logic                               blk_bout_s;
    logic                               blk_skip_s;
    logic                               last_blk_s;

    // The single block slice walks across the operands under count_r.
    subtract_block #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_blk (
        .a          (a_r[count_r]),
        .b          (b_r[count_r]),
        .borrow_in  (borrow_r),
        .diff       (blk_diff_s),
        .borrow_out (blk_bout_s),
        .skip       (blk_skip_s)
    );

    assign last_blk_s = (count_r == CW'(NBLK - 1));
    assign in_ready   = (state_r == IDLE) & ~rst;
    assign out_valid  = (state_r == DONE);
    assign Diff       = diff_r;
    assign Bout       = bout_r;
    assign V          = v_r;
    assign skip_mask  = skip_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_blk_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, per-block result write-back and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            count_r  <= '0;
            bout_r   <= 1'b0;
            v_r      <= 1'b0;
            skip_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        borrow_r <= Bin;
                        diff_r   <= '0;
                        skip_r   <= '0;
                        v_r      <= 1'b0;
                        count_r  <= '0;
                    end
                end
                BUSY: begin
                    diff_r[count_r] <= blk_diff_s;
                    skip_r[count_r] <= blk_skip_s;
                    borrow_r        <= blk_bout_s;
                    if (last_blk_s) begin
                        count_r <= '0;
                        bout_r  <= blk_bout_s;
                        // blk_diff_s holds the top block, so its MSB is Diff's MSB.
                        v_r     <= signed_ovf(a_r[NBLK-1][BLOCK_SIZE-1],
                                              b_r[NBLK-1][BLOCK_SIZE-1],
                                              blk_diff_s[BLOCK_SIZE-1]);
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                DONE: begin
                    diff_r <= diff_r;
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_serial_subtractor.sv
module tb_block_serial_subtractor;

    localparam int W  = 16;
    localparam int NB = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        v;
        logic [3:0]  skip;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        Bin = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] Diff;
    logic        Bout;
    logic        V;
    logic [3:0]  skip_mask;

    int checks = 0;
    int errors = 0;

    block_serial_subtractor #(.WIDTH(W), .BLOCK_SIZE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .V         (V),
        .skip_mask (skip_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        vec_t r;
        int ua, ub, ud, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        ud = ua - ub - int'(bin);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb - int'(bin);
        r.a    = a;
        r.b    = b;
        r.bin  = bin;
        r.diff = ud[15:0];
        r.bout = (ud < 0);
        r.v    = (sd > 32767) || (sd < -32768);
        for (int j = 0; j < NB; j++) begin
            r.skip[j] = (a[j*4 +: 4] == b[j*4 +: 4]);
        end
        return r;
    endfunction

    // Run one operation; hold = cycles out_ready stays low after out_valid.
    task automatic do_op(input vec_t v, input int hold, input string tag);
        int n;
        out_ready = (hold == 0);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        A = v.a;
        B = v.b;
        Bin = v.bin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        Bin = 1'($urandom);
        chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(NB));
        chk({tag, " diff"}, 32'(Diff), 32'(v.diff));
        chk({tag, " bout"}, 32'(Bout), 32'(v.bout));
        chk({tag, " v"}, 32'(V), 32'(v.v));
        chk({tag, " skip"}, 32'(skip_mask), 32'(v.skip));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_diff"}, 32'({Diff, Bout, V, skip_mask}),
                32'({v.diff, v.bout, v.v, v.skip}));
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t rv;
        tbl[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 4'b0011};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'b1110};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 4'b0110};
        tbl[3] = '{16'hAAAA, 16'hAAAA, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111};
        tbl[4] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b1110};

        // Reset state.
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst outputs", 32'({out_valid, Diff, Bout, V, skip_mask}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // Backpressure on the result, then back-to-back accept.
        do_op(tbl[0], 5, "hold");
        do_op(tbl[1], 0, "after_hold");

        // Asynchronous reset in the middle of BUSY.
        A = 16'h0000;
        B = 16'h0001;
        Bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst partial", 32'(Diff), 32'h0000_00FF);
        rst = 1'b1;
        #1;
        chk("async_rst outputs", 32'({out_valid, Diff, Bout, V, skip_mask}), 32'd0);
        chk("async_rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);
        do_op(tbl[4], 0, "post_rst");

        // Randomized operations against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rv = model(16'($urandom), 16'($urandom), 1'($urandom));
            if (k % 8 == 0) begin
                rv = model(rv.a, rv.a ^ 16'($urandom_range(15, 0)), rv.bin);
            end
            do_op(rv, $urandom_range(2, 0), $sformatf("rnd%0d", k));
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
